// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder: prefix/discard codes,
// FSM and class encodings, the 16-bit event record and the key classifier.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_NUL   = 8'h00;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_RSND  = 8'hFE;
  localparam logic [7:0] SC_ERR   = 8'hFF;

  localparam int EVT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXT     = 2'b01,
    ST_BRK     = 2'b10,
    ST_EXT_BRK = 2'b11
  } ps2_state_e;

  typedef enum logic [1:0] {
    CLS_HEX   = 2'b00,
    CLS_ENTER = 2'b01,
    CLS_BKSP  = 2'b10,
    CLS_OTHER = 2'b11
  } ps2_class_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [1:0] cls;
    logic [3:0] value;
  } ps2_evt_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == SC_NUL) || (b == SC_BAT) || (b == SC_ACK) ||
           (b == SC_RSND) || (b == SC_ERR);
  endfunction

  // Digit decoding applies to non-extended codes only; E0-prefixed codes
  // other than Enter all fall into the "other" class.
  function automatic ps2_evt_t classify(input logic [7:0] code, input logic ext,
                                        input logic brk);
    ps2_evt_t e;
    e.code  = code;
    e.ext   = ext;
    e.brk   = brk;
    e.cls   = CLS_OTHER;
    e.value = 4'h0;
    if (code == SC_ENTER) begin
      e.cls = CLS_ENTER;
    end else if (!ext && code == SC_BKSP) begin
      e.cls = CLS_BKSP;
    end else if (!ext) begin
      e.cls = CLS_HEX;
      case (code)
        8'h45, 8'h70: e.value = 4'h0;
        8'h16, 8'h69: e.value = 4'h1;
        8'h1E, 8'h72: e.value = 4'h2;
        8'h26, 8'h7A: e.value = 4'h3;
        8'h25, 8'h6B: e.value = 4'h4;
        8'h2E, 8'h73: e.value = 4'h5;
        8'h36, 8'h74: e.value = 4'h6;
        8'h3D, 8'h6C: e.value = 4'h7;
        8'h3E, 8'h75: e.value = 4'h8;
        8'h46, 8'h7D: e.value = 4'h9;
        8'h1C:        e.value = 4'hA;
        8'h32:        e.value = 4'hB;
        8'h21:        e.value = 4'hC;
        8'h23:        e.value = 4'hD;
        8'h24:        e.value = 4'hE;
        8'h2B:        e.value = 4'hF;
        default: begin
          e.cls   = CLS_OTHER;
          e.value = 4'h0;
        end
      endcase
    end else begin
      e.cls = CLS_OTHER;
    end
    return e;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead FIFO for decoded key events; the head entry is always on rd_data
// and reads as zero while the FIFO is empty.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CW'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: tracks E0/F0 prefixes, classifies completed key
// events and queues them for a valid/ready consumer.
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit EMIT_BREAK = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] dato,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_break,
  output logic [1:0] out_class,
  output logic [3:0] out_value,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ps2_state_e    state_q, state_d;
  logic          overflow_q, overflow_d;
  logic          evt_done_s, ext_s, brk_s, push_s, drop_s;
  logic          full_s, empty_s;
  logic [CW-1:0] count_s;
  ps2_evt_t      evt_s, head_s;

  assign ext_s = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign brk_s = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

  // Prefix tracking; only a non-prefix, non-discard byte completes an event.
  always_comb begin
    state_d    = state_q;
    evt_done_s = 1'b0;
    if (tick) begin
      if (dato == SC_EXT) begin
        state_d = ST_EXT;
      end else if (dato == SC_BRK) begin
        case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else if (is_discard(dato)) begin
        state_d = ST_IDLE;
      end else begin
        evt_done_s = 1'b1;
        state_d    = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    evt_s      = classify(dato, ext_s, brk_s);
    push_s     = evt_done_s & (~brk_s | EMIT_BREAK);
    drop_s     = push_s & full_s & ~out_ready;
    overflow_d = overflow_q | drop_s;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_s),
    .wr_data(evt_s),
    .pop    (out_ready),
    .rd_data(head_s),
    .count  (count_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  assign out_valid  = ~empty_s;
  assign out_code   = head_s.code;
  assign out_ext    = head_s.ext;
  assign out_break  = head_s.brk;
  assign out_class  = head_s.cls;
  assign out_value  = head_s.value;
  assign fifo_count = 3'(count_s);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: two decoders (EMIT_BREAK=0 and 1) driven in parallel from a
// vector table, plus hand-written sequences for overflow, reset and prefixes.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] dato = 8'h00;
  logic       out_ready = 1'b0;

  logic       o0_valid, o0_ext, o0_break, o0_ovf;
  logic [7:0] o0_code;
  logic [1:0] o0_class;
  logic [3:0] o0_value;
  logic [2:0] o0_count;
  logic       o1_valid, o1_ext, o1_break, o1_ovf;
  logic [7:0] o1_code;
  logic [1:0] o1_class;
  logic [3:0] o1_value;
  logic [2:0] o1_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .EMIT_BREAK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .dato(dato), .out_ready(out_ready),
    .out_valid(o0_valid), .out_code(o0_code), .out_ext(o0_ext), .out_break(o0_break),
    .out_class(o0_class), .out_value(o0_value), .fifo_count(o0_count), .overflow(o0_ovf)
  );

  ps2_scancode_decoder #(.FIFO_DEPTH(4), .EMIT_BREAK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .dato(dato), .out_ready(out_ready),
    .out_valid(o1_valid), .out_code(o1_code), .out_ext(o1_ext), .out_break(o1_break),
    .out_class(o1_class), .out_value(o1_value), .fifo_count(o1_count), .overflow(o1_ovf)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        two;
    logic        v0;
    logic        v1;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [15:0] mk(input logic [7:0] code, input logic ext,
                                     input logic brk, input logic [1:0] cls,
                                     input logic [3:0] val);
    return {code, ext, brk, cls, val};
  endfunction

  function automatic logic [15:0] head0();
    return {o0_code, o0_ext, o0_break, o0_class, o0_value};
  endfunction

  function automatic logic [15:0] head1();
    return {o1_code, o1_ext, o1_break, o1_class, o1_value};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tick = 1'b1;
    dato = b;
    @(negedge clk);
    tick = 1'b0;
    dato = 8'h00;
  endtask

  task automatic pop1();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{8'h00, 8'h16, 1'b0, 1'b1, 1'b1, mk(8'h16, 1'b0, 1'b0, 2'd0, 4'h1)};
    vecs[1]  = '{8'hF0, 8'h16, 1'b1, 1'b0, 1'b1, mk(8'h16, 1'b0, 1'b1, 2'd0, 4'h1)};
    vecs[2]  = '{8'hE0, 8'h5A, 1'b1, 1'b1, 1'b1, mk(8'h5A, 1'b1, 1'b0, 2'd1, 4'h0)};
    vecs[3]  = '{8'hE0, 8'h75, 1'b1, 1'b1, 1'b1, mk(8'h75, 1'b1, 1'b0, 2'd3, 4'h0)};
    vecs[4]  = '{8'h00, 8'h75, 1'b0, 1'b1, 1'b1, mk(8'h75, 1'b0, 1'b0, 2'd0, 4'h8)};
    vecs[5]  = '{8'h00, 8'h66, 1'b0, 1'b1, 1'b1, mk(8'h66, 1'b0, 1'b0, 2'd2, 4'h0)};
    vecs[6]  = '{8'h00, 8'h1C, 1'b0, 1'b1, 1'b1, mk(8'h1C, 1'b0, 1'b0, 2'd0, 4'hA)};
    vecs[7]  = '{8'h00, 8'h2B, 1'b0, 1'b1, 1'b1, mk(8'h2B, 1'b0, 1'b0, 2'd0, 4'hF)};
    vecs[8]  = '{8'h00, 8'h70, 1'b0, 1'b1, 1'b1, mk(8'h70, 1'b0, 1'b0, 2'd0, 4'h0)};
    vecs[9]  = '{8'h00, 8'h7D, 1'b0, 1'b1, 1'b1, mk(8'h7D, 1'b0, 1'b0, 2'd0, 4'h9)};
    vecs[10] = '{8'h00, 8'hAA, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{8'h00, 8'hFA, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{8'h00, 8'h5A, 1'b0, 1'b1, 1'b1, mk(8'h5A, 1'b0, 1'b0, 2'd1, 4'h0)};
    vecs[13] = '{8'h00, 8'h1B, 1'b0, 1'b1, 1'b1, mk(8'h1B, 1'b0, 1'b0, 2'd3, 4'h0)};
    vecs[14] = '{8'hF0, 8'h5A, 1'b1, 1'b0, 1'b1, mk(8'h5A, 1'b0, 1'b1, 2'd1, 4'h0)};

    // Reset state
    rst = 1'b0;
    idle(3);
    chk("reset_d0", {o0_valid, head0(), o0_count, o0_ovf}, 32'h0);
    chk("reset_d1", {o1_valid, head1(), o1_count, o1_ovf}, 32'h0);
    rst = 1'b1;
    idle(2);

    // Table vectors, each starting and ending with an empty FIFO
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].two) send(vecs[i].b0);
      send(vecs[i].b1);
      chk($sformatf("v%0d_valid0", i), {31'b0, o0_valid}, {31'b0, vecs[i].v0});
      chk($sformatf("v%0d_head0", i), {16'b0, head0()}, {16'b0, vecs[i].v0 ? vecs[i].exp : 16'h0});
      chk($sformatf("v%0d_count0", i), {29'b0, o0_count}, {31'b0, vecs[i].v0});
      chk($sformatf("v%0d_valid1", i), {31'b0, o1_valid}, {31'b0, vecs[i].v1});
      chk($sformatf("v%0d_head1", i), {16'b0, head1()}, {16'b0, vecs[i].v1 ? vecs[i].exp : 16'h0});
      pop1();
      chk($sformatf("v%0d_drain", i), {30'b0, o0_valid, o1_valid}, 32'h0);
    end

    // out_ready while empty has no effect on the next event
    pop1();
    send(8'h1E);
    chk("ready_empty_cnt", {29'b0, o0_count}, 32'd1);
    pop1();

    // Overflow: five makes with no consumer
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    chk("ovf_count", {29'b0, o0_count}, 32'd4);
    chk("ovf_flag", {31'b0, o0_ovf}, 32'd1);
    chk("ovf_head", {24'b0, o0_code}, 32'h16);
    // Push and pop together while full
    @(negedge clk);
    tick = 1'b1; dato = 8'h36; out_ready = 1'b1;
    @(negedge clk);
    tick = 1'b0; dato = 8'h00; out_ready = 1'b0;
    chk("full_pp_count", {29'b0, o0_count}, 32'd4);
    chk("full_pp_head", {24'b0, o0_code}, 32'h1E);
    pop1(); chk("drain_1", {24'b0, o0_code}, 32'h26);
    pop1(); chk("drain_2", {24'b0, o0_code}, 32'h25);
    pop1(); chk("drain_3", {16'b0, head0()}, {16'b0, mk(8'h36, 1'b0, 1'b0, 2'd0, 4'h6)});
    pop1();
    chk("drain_empty", {28'b0, o0_valid, o0_count}, 32'h0);
    chk("ovf_sticky", {31'b0, o0_ovf}, 32'd1);
    do_reset();
    chk("ovf_reset", {31'b0, o0_ovf}, 32'd0);

    // Reset in the middle of a prefix discards it
    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk("rst_prefix_head", {16'b0, head0()}, {16'b0, mk(8'h1C, 1'b0, 1'b0, 2'd0, 4'hA)});
    send(8'hAA);
    send(8'hFA);
    chk("discard_count", {29'b0, o0_count}, 32'd1);
    pop1();

    // Redundant F0 with long gaps between bytes
    send(8'hE0); idle(20);
    send(8'hF0); idle(20);
    send(8'hF0); idle(20);
    send(8'h5A);
    chk("ebrk_count1", {29'b0, o1_count}, 32'd1);
    chk("ebrk_head1", {16'b0, head1()}, {16'b0, mk(8'h5A, 1'b1, 1'b1, 2'd1, 4'h0)});
    chk("ebrk_count0", {29'b0, o0_count}, 32'd0);
    pop1();
    chk("ebrk_drain", {31'b0, o1_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits between the PS/2 byte receiver and the application consumer.
- Takes raw Set-2 scan-code bytes (dato plus one-cycle tick) and tracks the E0/F0 prefixes.
- Classifies each completed key event and maps hex and keypad digits to a 4-bit value.
- Buffers events in a small show-ahead FIFO with a valid/ready handshake toward the consumer.

Parameters:
- FIFO_DEPTH, 4, number of event entries; power of 2, minimum 2.
- EMIT_BREAK, 0, 1 = push break (key-release) events too; 0 = drop them.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle strobe; dato valid this cycle
- dato  in  8  received scan-code byte
- out_ready  in  1  consumer accepts head event
- out_valid  out  1  FIFO non-empty
- out_code  out  8  final (non-prefix) scan byte of head event
- out_ext  out  1  head event was E0-prefixed
- out_break  out  1  head event was F0-prefixed (release)
- out_class  out  2  00 hex digit, 01 enter, 10 backspace, 11 other
- out_value  out  4  digit value when class=00, else 0
- fifo_count  out  3  occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- Reset state (rst=0 at a clk edge): FSM goes to IDLE, FIFO is emptied, overflow=0. All outputs read 0, including fifo_count.
- Reset mid-prefix sequence: the pending prefix is discarded.
- FSM states: IDLE, EXT, BRK, EXT_BRK. The FSM advances only on tick=1; with tick=0 it holds.
- E0 received in any state -> EXT.
- F0 received: IDLE -> BRK, EXT -> EXT_BRK. In BRK or EXT_BRK it stays in the same state (redundant prefix).
- Discard bytes 00, AA, FA, FE, FF: no event, go to IDLE.
- Any other byte completes an event, with ext = state in {EXT, EXT_BRK} and brk = state in {BRK, EXT_BRK}; then go to IDLE.
- Classification, non-extended codes only:
  - Hex digits 0..F: 45, 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46, 1C, 32, 21, 23, 24, 2B.
  - Keypad digits 0..9: 70, 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D.
  - Class 00 uses those values.
- 5A (plain or extended) -> class 01. 66 -> class 10. Everything else, including all other extended codes -> class 11, value 0.
- Push rule: push when an event completes AND (brk=0 OR EMIT_BREAK=1). Typematic repeats push normally.
- FIFO is show-ahead: out_* always reflect the head entry. When empty, out_* read 0.
- Latency: tick with the completing byte at edge N -> out_valid=1 after edge N (visible in cycle N+1), provided the FIFO was empty. No combinational path from tick/dato to the outputs.
- Pop on out_valid & out_ready. out_ready while empty has no effect.
- Full with push and no pop: the event is dropped and overflow is set. overflow clears only on reset.
- Full with push and pop in the same cycle: both happen, and fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is updated in the same edge as push/pop.

Decomposition:
- Package ps2_kbd_pkg holds:
  - scan-code constants (E0, F0, discard codes, enter, backspace);
  - the FSM state encoding;
  - the class encoding;
  - the event record layout: code 8, ext 1, brk 1, class 2, value 4 = 16 bits.
- Classification is a pure function in the package.
- Sub-module ps2_evt_fifo: parameterised 16-bit show-ahead FIFO with count and full/empty flags, and the same synchronous active-low reset.

Test Plan:
- Reset, then tick with 16 -> out_valid=1 the next cycle, code=16, class=00, value=1, ext=0, brk=0. Pulse out_ready -> out_valid=0.
- Sequence F0,16 with EMIT_BREAK=0 -> no event, fifo_count stays 0. Same with EMIT_BREAK=1 -> one event, brk=1, value=1.
- Sequence E0,5A -> class=01, ext=1. E0,75 -> class=11, value=0, ext=1. Plain 75 -> class=00, value=8.
- Hold out_ready=0 and send 5 digit make codes -> fifo_count=4, overflow=1, and head is the first code. Next, send a 6th code in the same cycle as an out_ready pulse -> fifo_count stays 4 and the 6th code is stored at the tail.
- Send E0, then assert rst=0 for one cycle, then send 1C -> event ext=0, class=00, value=A. Send AA or FA -> no event.
- Sequence E0,F0,F0,5A -> a single event with ext=1, brk=1 (EMIT_BREAK=1). Gaps of many idle cycles between the bytes do not change the result.
